mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N:1 channel multiplexer with a direct-select mode and an auto-scan mode. It generalises the team's fixed 8:1 combinational mux to CHANNELS inputs of WIDTH bits each. The selected sample lands in a one-entry output register with a valid/ready handshake, so downstream logic can stall it. Auto-scan walks the channels round-robin with a programmable dwell. Typical use is front-ending a shared serialiser or sampler.

## Interface
- WIDTH, 8, bits per channel
- CHANNELS, 8, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), channel index width
- DWELL_W, 8, dwell counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- sel  in  SEL_W  channel index, direct mode
- mode  in  1  0 = direct, 1 = auto-scan; sampled only in IDLE
- dwell  in  DWELL_W  cycles to wait per channel in scan; sampled at each channel entry
- start  in  1  begin scan (IDLE and mode=1)
- stop  in  1  end scan, return to IDLE
- out  out  WIDTH  captured sample
- out_ch  out  SEL_W  channel index of out
- out_valid  out  1  out/out_ch hold a sample
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  FSM not in IDLE
- sel_err  out  1  one-cycle pulse: direct-mode sel ≥ CHANNELS

## Operation
- Reset values: out=0, out_ch=0, out_valid=0, busy=0, sel_err=0, FSM=IDLE, scan channel=0, dwell counter=0.
- Slot free ≡ !out_valid | out_ready. A capture may only happen when the slot is free. Capture loads out, out_ch and sets out_valid=1. Acceptance without a same-cycle capture clears out_valid. A held sample stays stable until accepted.
- FSM has two states: IDLE and DWELL.
- IDLE with mode=0 (direct): each cycle with the slot free:
  - if sel < CHANNELS, capture in[sel] with out_ch=sel;
  - otherwise, no capture and sel_err=1 for that cycle.
- IDLE with mode=1 and start=1 → DWELL with channel=0 and counter=dwell. No direct captures happen while mode=1.
- DWELL:
  - counter ≠ 0: decrement.
  - counter = 0 and slot free: capture the current channel, advance the channel (CHANNELS-1 wraps to 0), reload counter=dwell.
  - counter = 0 and slot not free: hold with counter at 0. The scan stalls; no channel is skipped.
- stop=1 in DWELL → IDLE at the next edge, with no capture in that cycle. A pending output sample is kept until accepted.
- start and stop asserted together: stop wins, and the FSM stays in or goes to IDLE.
- A mode change during DWELL is ignored until the FSM returns to IDLE.
- Asynchronous reset mid-operation immediately forces all reset values. Any pending sample is discarded.
- Unused bits beyond CHANNELS*WIDTH do not exist. sel out of range never indexes past the in vector.

## Timing
- Direct latency is 1 cycle: sel/in present in cycle t give out valid in cycle t+1.
- Direct throughput is 1 sample/cycle with out_ready held high.
- Scan: start at cycle t → busy=1 from t+1. The channel-0 capture happens at the end of cycle t+1+dwell, so out_valid=1 at t+2+dwell.
- Scan period per channel is dwell+1 cycles with no backpressure. dwell=0 gives one channel per cycle.
- Backpressure adds exactly the number of stalled cycles to the period.
- sel_err is registered: it is asserted in cycle t+1 for a bad sel in cycle t.
- out_ready is combinationally observed. No combinational path runs from out_ready to out_valid or out.

## Test plan
- **Direct sweep.** WIDTH=1, CHANNELS=8, in=8'b10101010, out_ready=1. Drive sel=0..7, one per cycle. → out is 0,1,0,1,0,1,0,1, each one cycle later; out_ch matches sel.
- **Out-of-range select.** CHANNELS=6, sel=7. → no capture, out_valid drops after the pending sample is accepted, sel_err pulses 1 cycle; sel=5 then captures normally.
- **Scan with dwell and wrap.** CHANNELS=4, dwell=2, in={4'hD,4'hC,4'hB,4'hA}, start pulse at t. → captures of out_ch 0,1,2,3,0 with out A,B,C,D,A at t+4, t+7, t+10, t+13, t+16. stop at t+17 → busy=0 at t+18.
- **Backpressure stall.** Scan with dwell=0, out_ready=0 for 5 cycles after the first capture. → out=channel 0 held stable, the next capture is channel 1 (no skip), out_valid stays 1 throughout.
- **Start/stop collision and mode change.** start=stop=1 in IDLE → busy stays 0. During DWELL, mode set to 0 → scanning continues until stop.
- **Reset mid-scan.** Assert rst asynchronously during DWELL with out_valid=1. → all outputs go to their reset values before the next clock edge. After release, direct mode resumes with a 1-cycle latency.

Source files
------------

// File: rtl/mux_scan.sv
// Registered CHANNELS:1 multiplexer with direct-select and round-robin auto-scan
// modes, feeding a one-entry valid/ready output register.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      sel_err
);

  localparam logic IDLE  = 1'b0;
  localparam logic DWELL = 1'b1;

  logic               state;
  logic [SEL_W-1:0]   ch;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   ch_next;
  logic [WIDTH-1:0]   dir_data;
  logic [WIDTH-1:0]   scan_data;
  logic               slot_free;
  logic               sel_ok;
  logic               direct;
  logic               cap_dir;
  logic               cap_scan;
  logic               bad_sel;

  assign slot_free = !out_valid || out_ready;
  assign sel_ok    = 32'(sel) < 32'(CHANNELS);
  assign direct    = (state == IDLE) && !mode;
  assign cap_dir   = direct && slot_free && sel_ok;
  assign bad_sel   = direct && slot_free && !sel_ok;
  assign cap_scan  = (state == DWELL) && !stop && (cnt == '0) && slot_free;
  assign ch_next   = (32'(ch) == 32'(CHANNELS - 1)) ? '0 : ch + SEL_W'(1);
  assign busy      = (state == DWELL);

  // Compare-and-select muxes: an out-of-range sel matches no channel, so the
  // in vector is never indexed past its last channel.
  always_comb begin
    dir_data  = '0;
    scan_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(sel) == c) dir_data  = in[c*WIDTH +: WIDTH];
      if (32'(ch)  == c) scan_data = in[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      cnt       <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= bad_sel;

      if (state == IDLE) begin
        if (mode && start && !stop) begin
          state <= DWELL;
          ch    <= '0;
          cnt   <= dwell;
        end
      end else begin
        if (stop) begin
          state <= IDLE;
        end else if (cnt != '0) begin
          cnt <= cnt - DWELL_W'(1);
        end else if (slot_free) begin
          ch  <= ch_next;
          cnt <= dwell;
        end
      end

      if (cap_dir) begin
        out       <= dir_data;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else if (cap_scan) begin
        out       <= scan_data;
        out_ch    <= ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: a cycle-level behavioural model queues the
// expected samples, and a monitor checks them as the DUT presents them.
module tb_mux_scan;

  localparam int W   = 8;
  localparam int CH  = 6;
  localparam int SW  = $clog2(CH);
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] in;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [DW-1:0]   dwell;
  logic            start;
  logic            stop;
  logic [W-1:0]    out;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            sel_err;

  mux_scan #(.WIDTH(W), .CHANNELS(CH), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .mode(mode), .dwell(dwell),
    .start(start), .stop(stop), .out(out), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: scanning flag, next channel to capture, cycles left to wait.
  bit m_scan, m_valid, m_err;
  int m_next, m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] chan(input int c);
    logic [CH*W-1:0] v;
    v = in;
    return v[c*W +: W];
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_scan = 0; m_valid = 0; m_err = 0; m_next = 0; m_wait = 0;
        q.delete();
      end else begin
        bit free, cap;
        int cc;
        free = !m_valid || out_ready;
        cap = 0; cc = 0; m_err = 0;
        if (!m_scan) begin
          if (!mode) begin
            if (free) begin
              if (int'(sel) < CH) begin cap = 1; cc = int'(sel); end
              else m_err = 1;
            end
          end else if (start && !stop) begin
            m_scan = 1; m_next = 0; m_wait = int'(dwell);
          end
        end else if (stop) begin
          m_scan = 0;
        end else if (m_wait > 0) begin
          m_wait--;
        end else if (free) begin
          cap = 1; cc = m_next;
          m_next = (m_next + 1) % CH;
          m_wait = int'(dwell);
        end
        if (cap) begin
          q.push_back(ent_t'{d: chan(cc), c: SW'(cc)});
          m_valid = 1;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // Monitor: every presented sample must equal the queue head; pop on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_scan));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("queue_empty", 32'(out_valid), 32'd0);
          end else begin
            chk("out", 32'(out), 32'(q[0].d));
            chk("out_ch", 32'(out_ch), 32'(q[0].c));
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in = '0; sel = '0; mode = 1'b0; dwell = '0;
    start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    tick(2);
    chk_reset_vals();
    rst = 1'b0;

    // Direct sweep including the two out-of-range indices
    in = {CH*W/16{16'hA55A}};
    for (int s = 0; s < 8; s++) begin
      sel = SW'(s);
      tick();
    end
    sel = 3'd5;
    tick(2);

    // Direct mode, random select and backpressure
    for (int i = 0; i < 80; i++) begin
      in = {$urandom, $urandom};
      sel = SW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    tick(2);

    // Scan, dwell=2, wraps after the last channel
    in = {8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    mode = 1'b1; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("scan_busy_t1", 32'(busy), 32'd1);
    tick(20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("scan_stop_busy", 32'(busy), 32'd0);
    tick(2);

    // Backpressure stall with dwell=0
    dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(1);
    out_ready = 1'b0;
    tick(5);
    out_ready = 1'b1;
    tick(8);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start/stop collision, then mode change ignored while scanning
    start = 1'b1; stop = 1'b1;
    tick();
    chk("collision_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    tick();
    start = 1'b0; dwell = 8'd1;
    mode = 1'b0;
    tick(10);
    chk("mode_change_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(3);

    // Random mix of everything
    for (int i = 0; i < 500; i++) begin
      in = {$urandom, $urandom};
      sel = SW'($urandom_range(0, 7));
      mode = ($urandom_range(0, 2) != 0);
      dwell = DW'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    stop = 1'b1; start = 1'b0;
    tick();
    stop = 1'b0;

    // Asynchronous reset mid-scan with a held sample
    mode = 1'b1; dwell = 8'd0; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick(3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick(2);
    mode = 1'b0; out_ready = 1'b1; sel = 3'd2;
    in = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b0;
    tick();
    chk("post_rst_latency_data", 32'(out), 32'h33);
    chk("post_rst_latency_valid", 32'(out_valid), 32'd1);
    sel = 3'd4;
    tick(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
